pc_gen: RTL and testbench

Sequential, parametrised successor to the combinational next-PC calculator. It owns the architectural PC register and hands it to fetch through a valid/ready handshake. It accepts one resolved instruction at a time from execute and computes the next PC for RV32I jal/jalr/branches. It adds trap redirect, alignment checking, halt and error states, and retire and taken-branch counters.

---
 rtl/pc_gen_if.sv | 37 +++
 rtl/pc_gen.sv | 185 ++++++++++++++++++
 tb/tb_pc_gen.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch/execute handshake bundle for pc_gen: PC offer to fetch, resolved-instruction
// intake from execute, and status/counter outputs.
interface pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  io_pc;
  logic             io_pc_valid;
  logic             io_pc_ready;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [31:0]      io_instruction;
  logic [XLEN-1:0]  io_rs1_data;
  logic [XLEN-1:0]  io_rs2_data;
  logic [3:0]       io_pc_next_type;
  logic             io_trap;
  logic [XLEN-1:0]  io_trap_vector;
  logic             io_halted;
  logic             io_error;
  logic [1:0]       io_err_cause;
  logic [CNT_W-1:0] io_retired;
  logic [CNT_W-1:0] io_taken;

  modport master (
    output io_pc, io_pc_valid, io_in_ready, io_halted, io_error, io_err_cause,
           io_retired, io_taken,
    input  io_pc_ready, io_in_valid, io_instruction, io_rs1_data, io_rs2_data,
           io_pc_next_type, io_trap, io_trap_vector
  );

  modport slave (
    input  io_pc, io_pc_valid, io_in_ready, io_halted, io_error, io_err_cause,
           io_retired, io_taken,
    output io_pc_ready, io_in_valid, io_instruction, io_rs1_data, io_rs2_data,
           io_pc_next_type, io_trap, io_trap_vector
  );
endinterface

// File: rtl/pc_gen.sv
// Architectural PC owner: offers the PC to fetch, takes one resolved instruction from
// execute, and computes the next PC for RV32I jal/jalr/branches with trap/halt/error.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter bit              C_EXT        = 1'b0,
  parameter int              CNT_W        = 32
) (
  input  logic      clock,
  input  logic      reset,
  pc_gen_if.master  bus
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_ERROR} state_t;

  localparam logic [3:0] T_SEQ  = 4'd0;
  localparam logic [3:0] T_JAL  = 4'd1;
  localparam logic [3:0] T_JALR = 4'd2;
  localparam logic [3:0] T_UNK  = 4'd3;
  localparam logic [3:0] T_HALT = 4'd4;
  localparam logic [3:0] T_BNE  = 4'd5;
  localparam logic [3:0] T_BEQ  = 4'd6;
  localparam logic [3:0] T_BGE  = 4'd7;
  localparam logic [3:0] T_BGEU = 4'd8;
  localparam logic [3:0] T_BLT  = 4'd9;
  localparam logic [3:0] T_BLTU = 4'd10;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_TYPE  = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN = 2'd2;

  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0]  LSB_CLEAR = ~XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] i);
    return {{(XLEN-12){i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] i);
    return {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] i);
    return {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic branch_taken(input logic [3:0] ty,
                                        input logic signed [XLEN-1:0] a,
                                        input logic signed [XLEN-1:0] b);
    logic r;
    r = 1'b0;
    case (ty)
      T_BNE:   r = (a != b);
      T_BEQ:   r = (a == b);
      T_BGE:   r = (a >= b);
      T_BGEU:  r = ($unsigned(a) >= $unsigned(b));
      T_BLT:   r = (a < b);
      T_BLTU:  r = ($unsigned(a) < $unsigned(b));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [XLEN-1:0] t);
    return C_EXT ? t[0] : (t[1:0] != 2'b00);
  endfunction

  function automatic logic reserved_type(input logic [3:0] ty);
    return (ty == T_UNK) || (ty >= 4'd11);
  endfunction

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [1:0]             cause_q, cause_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic [CNT_W-1:0]       taken_q, taken_d;

  logic [XLEN-1:0]        target;
  logic                   redirect;
  logic [3:0]             ntype;
  logic [31:0]            instr;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   unused_opcode;

  assign ntype = bus.io_pc_next_type;
  assign instr = bus.io_instruction;
  assign rs1_s = bus.io_rs1_data;
  assign rs2_s = bus.io_rs2_data;
  // The opcode field carries no information here; the type input already decodes it.
  assign unused_opcode = ^instr[6:0];

  // Candidate target and whether it counts as a taken control transfer.
  always_comb begin
    target   = pc_q + PC_STEP;
    redirect = 1'b0;
    case (ntype)
      T_SEQ: begin
        target = pc_q + PC_STEP;
      end
      T_JAL: begin
        target   = pc_q + $unsigned(imm_j(instr));
        redirect = 1'b1;
      end
      T_JALR: begin
        target   = $unsigned(rs1_s + imm_i(instr)) & LSB_CLEAR;
        redirect = 1'b1;
      end
      T_BNE, T_BEQ, T_BGE, T_BGEU, T_BLT, T_BLTU: begin
        if (branch_taken(ntype, rs1_s, rs2_s)) begin
          target   = pc_q + $unsigned(imm_b(instr));
          redirect = 1'b1;
        end
      end
      default: begin
        target   = pc_q + PC_STEP;
        redirect = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    case (state_q)
      S_FETCH: begin
        if (bus.io_pc_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.io_in_valid) begin
          retired_d = retired_q + CNT_ONE;
          // Trap wins over everything, including a reserved or halt type.
          if (bus.io_trap) begin
            pc_d    = bus.io_trap_vector;
            state_d = S_FETCH;
          end else if (reserved_type(ntype)) begin
            state_d = S_ERROR;
            cause_d = CAUSE_TYPE;
          end else if (ntype == T_HALT) begin
            state_d = S_HALT;
          end else if (misaligned(target)) begin
            state_d = S_ERROR;
            cause_d = CAUSE_ALIGN;
          end else begin
            pc_d    = target;
            state_d = S_FETCH;
            if (redirect) taken_d = taken_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign bus.io_pc        = pc_q;
  assign bus.io_pc_valid  = (state_q == S_FETCH);
  assign bus.io_in_ready  = (state_q == S_EXEC);
  assign bus.io_halted    = (state_q == S_HALT);
  assign bus.io_error     = (state_q == S_ERROR);
  assign bus.io_err_cause = cause_q;
  assign bus.io_retired   = retired_q;
  assign bus.io_taken     = taken_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (4-byte and 2-byte alignment) driven in lockstep,
// checked every cycle against a behavioural model plus hand-computed expectations.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam int MF = 0, ME = 1, MH = 2, MX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_ready = 1'b0, in_valid = 1'b0, trap = 1'b0;
  logic [31:0] instr = '0, rs1 = '0, rs2 = '0, trap_vec = '0;
  logic [3:0]  ntype = '0;
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pc_gen_if #(.XLEN(32), .CNT_W(32)) if0 ();
  pc_gen_if #(.XLEN(32), .CNT_W(32)) if1 ();

  assign if0.io_pc_ready = pc_ready;      assign if1.io_pc_ready = pc_ready;
  assign if0.io_in_valid = in_valid;      assign if1.io_in_valid = in_valid;
  assign if0.io_instruction = instr;      assign if1.io_instruction = instr;
  assign if0.io_rs1_data = rs1;           assign if1.io_rs1_data = rs1;
  assign if0.io_rs2_data = rs2;           assign if1.io_rs2_data = rs2;
  assign if0.io_pc_next_type = ntype;     assign if1.io_pc_next_type = ntype;
  assign if0.io_trap = trap;              assign if1.io_trap = trap;
  assign if0.io_trap_vector = trap_vec;   assign if1.io_trap_vector = trap_vec;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b0), .CNT_W(32)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.master));
  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.master));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: next PC from the ISA rules using plain integer arithmetic.
  function automatic logic [31:0] model_target(input logic [3:0] ty, input logic [31:0] i,
                                               input logic [31:0] pc, input logic [31:0] a,
                                               input logic [31:0] b, output bit jumped);
    longint off;
    bit     cond;
    jumped = 0;
    cond   = 0;
    case (ty)
      4'd1: begin
        off = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) off -= 1048576;
        jumped = 1;
        return 32'(longint'(pc) + off);
      end
      4'd2: begin
        off = longint'(i[30:20]);
        if (i[31]) off -= 2048;
        jumped = 1;
        return 32'(longint'(a) + off) & 32'hFFFF_FFFE;
      end
      4'd5:  cond = (a != b);
      4'd6:  cond = (a == b);
      4'd7:  cond = ($signed(a) >= $signed(b));
      4'd8:  cond = (a >= b);
      4'd9:  cond = ($signed(a) < $signed(b));
      4'd10: cond = (a < b);
      default: cond = 0;
    endcase
    if (cond) begin
      off = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      if (i[31]) off -= 4096;
      jumped = 1;
      return 32'(longint'(pc) + off);
    end
    return pc + 32'd4;
  endfunction

  int          m_mode  [2];
  logic [31:0] m_pc    [2];
  logic [1:0]  m_cause [2];
  logic [31:0] m_ret   [2];
  logic [31:0] m_tkn   [2];

  always @(posedge clock or negedge reset) begin
    logic [31:0] t;
    bit jumped, bad;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = MF; m_pc[k] = RV; m_cause[k] = 2'd0; m_ret[k] = 0; m_tkn[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_mode[k] == MF && pc_ready) begin
          m_mode[k] = ME;
        end else if (m_mode[k] == ME && in_valid) begin
          m_ret[k] = m_ret[k] + 1;
          if (trap) begin
            m_pc[k] = trap_vec; m_mode[k] = MF;
          end else if (ntype == 4'd3 || ntype >= 4'd11) begin
            m_mode[k] = MX; m_cause[k] = 2'd1;
          end else if (ntype == 4'd4) begin
            m_mode[k] = MH;
          end else begin
            t   = model_target(ntype, instr, m_pc[k], rs1, rs2, jumped);
            bad = (k == 1) ? (t % 2 != 0) : (t % 4 != 0);
            if (bad) begin
              m_mode[k] = MX; m_cause[k] = 2'd2;
            end else begin
              m_pc[k] = t; m_mode[k] = MF;
              if (jumped) m_tkn[k] = m_tkn[k] + 1;
            end
          end
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [31:0] pc, input logic pv, input logic ir,
                     input logic h, input logic e, input logic [1:0] c,
                     input logic [31:0] r, input logic [31:0] tk);
    check($sformatf("dut%0d.pc", k), pc, m_pc[k]);
    check($sformatf("dut%0d.pc_valid", k), 32'(pv), 32'(m_mode[k] == MF));
    check($sformatf("dut%0d.in_ready", k), 32'(ir), 32'(m_mode[k] == ME));
    check($sformatf("dut%0d.halted", k), 32'(h), 32'(m_mode[k] == MH));
    check($sformatf("dut%0d.error", k), 32'(e), 32'(m_mode[k] == MX));
    check($sformatf("dut%0d.err_cause", k), 32'(c), 32'(m_cause[k]));
    check($sformatf("dut%0d.retired", k), r, m_ret[k]);
    check($sformatf("dut%0d.taken", k), tk, m_tkn[k]);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp(0, if0.io_pc, if0.io_pc_valid, if0.io_in_ready, if0.io_halted, if0.io_error,
          if0.io_err_cause, if0.io_retired, if0.io_taken);
      cmp(1, if1.io_pc, if1.io_pc_valid, if1.io_in_ready, if1.io_halted, if1.io_error,
          if1.io_err_cause, if1.io_retired, if1.io_taken);
    end
  end

  // Hand-computed expectation for every output of one instance.
  task automatic lit(input string tag, input int k, input logic [31:0] pc, input bit pv,
                     input bit ir, input bit h, input bit e, input logic [1:0] c,
                     input logic [31:0] r, input logic [31:0] tk);
    if (k == 0) begin
      check({tag, ".pc"}, if0.io_pc, pc);
      check({tag, ".pc_valid"}, 32'(if0.io_pc_valid), 32'(pv));
      check({tag, ".in_ready"}, 32'(if0.io_in_ready), 32'(ir));
      check({tag, ".halted"}, 32'(if0.io_halted), 32'(h));
      check({tag, ".error"}, 32'(if0.io_error), 32'(e));
      check({tag, ".err_cause"}, 32'(if0.io_err_cause), 32'(c));
      check({tag, ".retired"}, if0.io_retired, r);
      check({tag, ".taken"}, if0.io_taken, tk);
    end else begin
      check({tag, ".pc1"}, if1.io_pc, pc);
      check({tag, ".pc_valid1"}, 32'(if1.io_pc_valid), 32'(pv));
      check({tag, ".in_ready1"}, 32'(if1.io_in_ready), 32'(ir));
      check({tag, ".halted1"}, 32'(if1.io_halted), 32'(h));
      check({tag, ".error1"}, 32'(if1.io_error), 32'(e));
      check({tag, ".err_cause1"}, 32'(if1.io_err_cause), 32'(c));
      check({tag, ".retired1"}, if1.io_retired, r);
      check({tag, ".taken1"}, if1.io_taken, tk);
    end
  endtask

  task automatic do_fetch();
    int n = 0;
    while (!if0.io_pc_valid) begin
      if (n == 20) begin
        n_checks++; n_fail++;
        $display("FAIL fetch_wait: actual pc_valid=0 after %0d cycles required 1", n);
        return;
      end
      @(negedge clock);
      n++;
    end
    pc_ready = 1'b1;
    @(negedge clock);
    pc_ready = 1'b0;
  endtask

  task automatic do_exec(input logic [3:0] ty, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic tr, input logic [31:0] tv);
    int n = 0;
    while (!if0.io_in_ready) begin
      if (n == 20) begin
        n_checks++; n_fail++;
        $display("FAIL exec_wait: actual in_ready=0 after %0d cycles required 1", n);
        return;
      end
      @(negedge clock);
      n++;
    end
    ntype = ty; instr = i; rs1 = a; rs2 = b; trap = tr; trap_vec = tv;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; trap = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    lit(tag, 0, RV, 1, 0, 0, 0, 2'd0, 0, 0);
    lit(tag, 1, RV, 1, 0, 0, 0, 2'd0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  localparam logic [31:0] B16  = 32'h0000_0863;  // branch, offset +16
  localparam logic [31:0] JM8  = 32'hFF9F_F06F;  // jal, offset -8
  localparam logic [31:0] JR0  = 32'h0000_0067;  // jalr, imm 0
  localparam logic [31:0] J256 = 32'h1000_0067;  // jalr, imm +0x100

  initial begin
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    lit("rst_hold", 0, RV, 1, 0, 0, 0, 2'd0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    lit("rst_rel", 0, RV, 1, 0, 0, 0, 2'd0, 0, 0);
    do_fetch();
    lit("hs", 0, RV, 0, 1, 0, 0, 2'd0, 0, 0);
    do_exec(4'd0, 32'h0000_0013, 0, 0, 0, 0);
    lit("seq", 0, 32'h8000_0004, 1, 0, 0, 0, 2'd0, 1, 0);

    pulse_reset("rst_a");
    do_fetch(); do_exec(4'd6, B16, 5, 5, 0, 0);
    lit("beq", 0, 32'h8000_0010, 1, 0, 0, 0, 2'd0, 1, 1);
    do_fetch(); do_exec(4'd9, B16, 32'hFFFF_FFFF, 1, 0, 0);
    lit("blt", 0, 32'h8000_0020, 1, 0, 0, 0, 2'd0, 2, 2);
    do_fetch(); do_exec(4'd10, B16, 32'hFFFF_FFFF, 1, 0, 0);
    lit("bltu", 0, 32'h8000_0024, 1, 0, 0, 0, 2'd0, 3, 2);
    do_fetch(); do_exec(4'd5, B16, 5, 5, 0, 0);
    lit("bne", 0, 32'h8000_0028, 1, 0, 0, 0, 2'd0, 4, 2);
    do_fetch(); do_exec(4'd7, B16, 32'hFFFF_FFFF, 1, 0, 0);
    lit("bge", 0, 32'h8000_002C, 1, 0, 0, 0, 2'd0, 5, 2);
    do_fetch(); do_exec(4'd8, B16, 32'hFFFF_FFFF, 1, 0, 0);
    lit("bgeu", 0, 32'h8000_003C, 1, 0, 0, 0, 2'd0, 6, 3);
    do_fetch(); do_exec(4'd1, JM8, 0, 0, 0, 0);
    lit("jal", 0, 32'h8000_0034, 1, 0, 0, 0, 2'd0, 7, 4);
    do_fetch(); do_exec(4'd2, J256, 32'h8000_0001, 0, 0, 0);
    lit("jalr", 0, 32'h8000_0100, 1, 0, 0, 0, 2'd0, 8, 5);
    do_fetch(); do_exec(4'd2, JR0, 32'h8000_0102, 0, 0, 0);
    lit("misal_c0", 0, 32'h8000_0100, 0, 0, 0, 1, 2'd2, 9, 5);
    lit("misal_c1", 1, 32'h8000_0102, 1, 0, 0, 0, 2'd0, 9, 6);

    pulse_reset("rst_err");
    do_fetch(); do_exec(4'd3, 0, 0, 0, 1, 32'h8000_1000);
    lit("trap", 0, 32'h8000_1000, 1, 0, 0, 0, 2'd0, 1, 0);
    do_fetch(); do_exec(4'd12, 0, 0, 0, 0, 0);
    lit("rsvd", 0, 32'h8000_1000, 0, 0, 0, 1, 2'd1, 2, 0);
    ntype = 4'd0; pc_ready = 1'b1; in_valid = 1'b1;
    repeat (5) @(negedge clock);
    pc_ready = 1'b0; in_valid = 1'b0;
    lit("err_sticky", 0, 32'h8000_1000, 0, 0, 0, 1, 2'd1, 2, 0);

    pulse_reset("rst_b");
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("stall.pc", if0.io_pc, RV);
      check("stall.pc_valid", 32'(if0.io_pc_valid), 32'd1);
    end
    do_fetch(); do_exec(4'd4, 0, 0, 0, 0, 0);
    lit("halt", 0, RV, 0, 0, 1, 0, 2'd0, 1, 0);
    pc_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      check("halt_hold", 32'(if0.io_halted), 32'd1);
    end
    pc_ready = 1'b0; in_valid = 1'b0;
    lit("halt_end", 0, RV, 0, 0, 1, 0, 2'd0, 1, 0);
    pulse_reset("rst_halt");
    repeat (2) @(negedge clock);
    lit("final", 0, RV, 1, 0, 0, 0, 2'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: actual time %0t required completion earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
